window_minmax_tracker: RTL and testbench
========================================

// Module: window_minmax_tracker
// PURPOSE
//  Downstream consumer of the 4-bit magnitude comparator. Accepts a stream of samples over a
//  valid/ready handshake and time-shares one external comparator: it drives the comparator's
//  A/B inputs and uses its gt/lt/eq flags to track running max and min. After every WIN samples
//  it presents one result (max, min, tie count) on a valid/ready output, then starts a new window.
// PARAMETERS
//  WIDTH   4   sample width; must equal the external comparator width
//  WIN     8   samples per window, legal range 2..255
//  CNT_W   8   width of the internal sample counter and of out_ties; must hold WIN-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      sample present
//  in_data    in   WIDTH  sample value (unsigned)
//  in_ready   out  1      block can accept a sample
//  cmp_a      out  WIDTH  to comparator A
//  cmp_b      out  WIDTH  to comparator B
//  cmp_gt     in   1      comparator A_gt_B
//  cmp_lt     in   1      comparator A_lt_B
//  cmp_eq     in   1      comparator A_eq_B
//  out_valid  out  1      window result available
//  out_max    out  WIDTH  largest sample in window
//  out_min    out  WIDTH  smallest sample in window
//  out_ties   out  CNT_W  tie count (see CONFIGURATION)
//  out_ready  in   1      consumer takes result
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low, on rst_n.
//  - Reset state: IDLE. in_ready=1, out_valid=0, out_max=out_min=out_ties=0, cmp_a=cmp_b=0, count=0.
//    Asserting rst_n=0 mid-window or mid-report discards all partial state immediately.
//  - States:
//    - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into samp_r and go to CMP_MAX.
//      If count==0, also load max_r=min_r=in_data.
//    - CMP_MAX: cmp_a=samp_r, cmp_b=max_r. If cmp_gt, max_r<=samp_r.
//      If cmp_eq and count!=0, ties_r++. Go to CMP_MIN.
//    - CMP_MIN: cmp_a=samp_r, cmp_b=min_r. If cmp_lt, min_r<=samp_r.
//      If count==WIN-1, go to REPORT; else count++ and go to IDLE.
//    - REPORT: out_valid=1 and out_max/out_min/out_ties held stable while out_valid=1.
//      On out_ready, go to IDLE and clear count and ties_r.
//  - Registered outputs (in_ready, out_valid) follow state; in_ready=0 in CMP_MAX, CMP_MIN and REPORT.
//  - Throughput: one sample per 3 cycles (accept, CMP_MAX, CMP_MIN). The result is valid in the
//    cycle after the last sample's CMP_MIN.
//  - The comparator is purely combinational. Its flags are sampled in the same cycle cmp_a/cmp_b
//    are driven, and ignored in IDLE and REPORT, where cmp_a=cmp_b=0.
//  - Ordering is unsigned. Equal values never update max_r or min_r.
//  - Backpressure: in_valid held while in_ready=0 is not consumed; the sample is taken in the next IDLE cycle.
//  - No overlap: a new window never starts while a result is pending. out_ready asserted outside
//    REPORT is ignored.
// CONFIGURATION
//  WMT_TIE_COUNT_EN defined:
//    - out_ties = number of samples in the window, excluding the first, that equalled the running
//      max at their compare (cmp_eq in CMP_MAX).
//  WMT_TIE_COUNT_EN undefined:
//    - ties_r logic is removed and out_ties is tied to 0.
//    - Port list is identical in both builds.
// TESTING  (WIN=4 unless noted; a behavioural 4-bit comparator is attached to cmp_*)
//  1. Samples 3,9,1,9, out_ready=1
//     -> out_valid for 1 cycle: out_max=9, out_min=1, out_ties=1 (0 without macro).
//  2. Samples 5,5,5,5 -> out_max=5, out_min=5, out_ties=3 (0 without macro).
//  3. Samples 15,0,7,8 with out_ready=0 for 5 cycles
//     -> out_valid held with max=15, min=0; in_ready=0 throughout; clears the cycle after out_ready=1.
//  4. in_valid held continuously with 1,2,3,4,6
//     -> in_ready pulses once per 3 cycles; the 5th sample (6) is not taken until after REPORT,
//        then starts a new window.
//  5. rst_n=0 after 2 samples (7,2) of a window, then samples 4,4,4,4
//     -> immediate reset values; result max=4, min=4 (no trace of 7/2).
//  6. Check cmp_a/cmp_b every cycle: (samp,max) in CMP_MAX, (samp,min) in CMP_MIN, 0/0 elsewhere.

Source files
------------

// File: rtl/window_minmax_tracker.sv
// Windowed running max/min tracker that time-shares one external magnitude comparator.
// Optional tie counting is enabled by defining WMT_TIE_COUNT_EN; otherwise out_ties reads 0.
module window_minmax_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WIN   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_ties,
  input  logic             out_ready
);

  typedef enum logic [1:0] {StIdle, StCmpMax, StCmpMin, StReport} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIN - 1);

  state_e           state_q;
  logic [WIDTH-1:0] samp_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      samp_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            samp_q   <= in_data;
            in_ready <= 1'b0;
            state_q  <= StCmpMax;
            // First sample of a window seeds both extremes.
            if (count_q == '0) begin
              max_q <= in_data;
              min_q <= in_data;
            end
          end
        end
        StCmpMax: begin
          if (cmp_gt) max_q <= samp_q;
          state_q <= StCmpMin;
        end
        StCmpMin: begin
          if (cmp_lt) min_q <= samp_q;
          if (count_q == LastIdx) begin
            out_valid <= 1'b1;
            state_q   <= StReport;
          end else begin
            count_q  <= count_q + CNT_W'(1);
            in_ready <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StReport: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count_q   <= '0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Comparator operands are only meaningful in the two compare states.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (state_q)
      StCmpMax: begin
        cmp_a = samp_q;
        cmp_b = max_q;
      end
      StCmpMin: begin
        cmp_a = samp_q;
        cmp_b = min_q;
      end
      default: ;
    endcase
  end

  assign out_max = max_q;
  assign out_min = min_q;

`ifdef WMT_TIE_COUNT_EN
  logic [CNT_W-1:0] ties_q;

  // The first sample always equals itself, so it is excluded from the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ties_q <= '0;
    end else if (state_q == StCmpMax && cmp_eq && count_q != '0) begin
      ties_q <= ties_q + CNT_W'(1);
    end else if (state_q == StReport && out_ready) begin
      ties_q <= '0;
    end
  end

  assign out_ties = ties_q;
`else
  logic unused_cmp_eq;
  assign unused_cmp_eq = cmp_eq;
  assign out_ties      = '0;
`endif

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Directed self-checking bench for window_minmax_tracker (WIN=4) with a behavioural comparator.
module tb_window_minmax_tracker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned WIN   = 4;
  localparam int unsigned CNT_W = 8;
`ifdef WMT_TIE_COUNT_EN
  localparam bit TiesEn = 1'b1;
`else
  localparam bit TiesEn = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             out_valid;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [CNT_W-1:0] out_ties;
  logic             out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  window_minmax_tracker #(
    .WIDTH(WIDTH),
    .WIN  (WIN),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_gt   (cmp_gt),
    .cmp_lt   (cmp_lt),
    .cmp_eq   (cmp_eq),
    .out_valid(out_valid),
    .out_max  (out_max),
    .out_min  (out_min),
    .out_ties (out_ties),
    .out_ready(out_ready)
  );

  assign cmp_gt = cmp_a > cmp_b;
  assign cmp_lt = cmp_a < cmp_b;
  assign cmp_eq = cmp_a == cmp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one sample and return at the negedge after it was accepted (DUT in CMP_MAX).
  task automatic push(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%b, required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    n_cmp++;
    if ({out_max, out_min, out_ties} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: max=%0d min=%0d ties=%0d, want 0/0/0",
                         out_max, out_min, out_ties);
    end
    n_cmp++;
    if ({cmp_a, cmp_b} !== '0) begin
      n_fail++; $display("FAIL reset_cmp: a=%0d b=%0d, want 0/0", cmp_a, cmp_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(4'd3);
    push(4'd9);
    push(4'd1);
    push(4'd9);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %b, want 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: got %b, want 1", out_valid);
    end
    n_cmp++;
    if (out_max !== 4'd9 || out_min !== 4'd1) begin
      n_fail++; $display("FAIL basic_maxmin: got %0d/%0d, want 9/1", out_max, out_min);
    end
    n_cmp++;
    if (out_ties !== (TiesEn ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL basic_ties: got %0d, want %0d", out_ties, TiesEn ? 1 : 0);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_one_cycle: valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(4'd5);
    wait_result();
    n_cmp++;
    if (out_max !== 4'd5 || out_min !== 4'd5) begin
      n_fail++; $display("FAIL ties_maxmin: got %0d/%0d, want 5/5", out_max, out_min);
    end
    n_cmp++;
    if (out_ties !== (TiesEn ? 8'd3 : 8'd0)) begin
      n_fail++; $display("FAIL ties_count: got %0d, want %0d", out_ties, TiesEn ? 3 : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(4'd15);
    push(4'd0);
    push(4'd7);
    push(4'd8);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid=%b ready=%b, want 1/0", i, out_valid, in_ready);
      end
      n_cmp++;
      if (out_max !== 4'd15 || out_min !== 4'd0) begin
        n_fail++; $display("FAIL bp_values_%0d: got %0d/%0d, want 15/0", i, out_max, out_min);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int seq [5];
    int exp_rdy [14];
    int idx;
    logic rdy_prev;
    seq     = '{1, 2, 3, 4, 6};
    exp_rdy = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    out_ready = 1'b1;
    idx = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'(seq[0]);
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (in_ready !== 1'(exp_rdy[i])) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %b, want %0d", i, in_ready, exp_rdy[i]);
      end
      if (i == 12) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_max !== 4'd4 || out_min !== 4'd1) begin
          n_fail++; $display("FAIL b2b_result: valid=%b max=%0d min=%0d, want 1/4/1",
                             out_valid, out_max, out_min);
        end
      end
      rdy_prev = in_ready;
      @(negedge clk);
      if (rdy_prev && idx < 4) begin
        idx++;
        in_data = 4'(seq[idx]);
      end
    end
    in_valid = 1'b0;
    // Sample 6 opened a fresh window; complete it.
    for (int i = 0; i < 3; i++) push(4'd7);
    wait_result();
    n_cmp++;
    if (out_max !== 4'd7 || out_min !== 4'd6) begin
      n_fail++; $display("FAIL b2b_new_window: got %0d/%0d, want 7/6", out_max, out_min);
    end
    n_cmp++;
    if (out_ties !== (TiesEn ? 8'd2 : 8'd0)) begin
      n_fail++; $display("FAIL b2b_ties: got %0d, want %0d", out_ties, TiesEn ? 2 : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_cmp_ports();
    logic [WIDTH-1:0] samples [4];
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    int n;
    samples = '{4'd10, 4'd12, 4'd4, 4'd4};
    out_ready = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (!in_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if (in_ready !== 1'b1 || cmp_a !== 4'd0 || cmp_b !== 4'd0) begin
        n_fail++; $display("FAIL cmp_idle_%0d: ready=%b a=%0d b=%0d, want 1/0/0",
                           s, in_ready, cmp_a, cmp_b);
      end
      if (s == 0) begin
        mx = samples[0];
        mn = samples[0];
      end
      in_valid = 1'b1;
      in_data  = samples[s];
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (cmp_a !== samples[s] || cmp_b !== mx) begin
        n_fail++; $display("FAIL cmp_max_%0d: a=%0d b=%0d, want %0d/%0d",
                           s, cmp_a, cmp_b, samples[s], mx);
      end
      if (samples[s] > mx) mx = samples[s];
      @(negedge clk);
      n_cmp++;
      if (cmp_a !== samples[s] || cmp_b !== mn) begin
        n_fail++; $display("FAIL cmp_min_%0d: a=%0d b=%0d, want %0d/%0d",
                           s, cmp_a, cmp_b, samples[s], mn);
      end
      if (samples[s] < mn) mn = samples[s];
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || cmp_a !== 4'd0 || cmp_b !== 4'd0) begin
      n_fail++; $display("FAIL cmp_report: valid=%b a=%0d b=%0d, want 1/0/0",
                         out_valid, cmp_a, cmp_b);
    end
    n_cmp++;
    if (out_max !== 4'd12 || out_min !== 4'd4 || out_ties !== 8'd0) begin
      n_fail++; $display("FAIL cmp_result: got %0d/%0d/%0d, want 12/4/0",
                         out_max, out_min, out_ties);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push(4'd7);
    push(4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_hs: ready=%b valid=%b, want 1/0", in_ready, out_valid);
    end
    n_cmp++;
    if ({out_max, out_min, out_ties, cmp_a, cmp_b} !== '0) begin
      n_fail++; $display("FAIL rst_mid_values: max=%0d min=%0d ties=%0d a=%0d b=%0d, want all 0",
                         out_max, out_min, out_ties, cmp_a, cmp_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(4'd4);
    wait_result();
    n_cmp++;
    if (out_max !== 4'd4 || out_min !== 4'd4) begin
      n_fail++; $display("FAIL rst_mid_result: got %0d/%0d, want 4/4", out_max, out_min);
    end
    n_cmp++;
    if (out_ties !== (TiesEn ? 8'd3 : 8'd0)) begin
      n_fail++; $display("FAIL rst_mid_ties: got %0d, want %0d", out_ties, TiesEn ? 3 : 0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_back_to_back();
    test_cmp_ports();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
